// File: rtl/instr_encoder.sv
// Assembles MIPS instruction words from decoded fields and writes them sequentially to program memory.
// Optional build macro INSTR_ENCODER_CHECKSUM_EN adds a running XOR checksum of written words.
//   state | meaning
//   IDLE  | ready for a field bundle
//   ENC   | encode captured fields into mem_wdata
//   WR    | single-cycle memory write strobe
//   FULL  | MEMORY_DEPTH words written, wait for clear
module instr_encoder #(
   parameter int MEMORY_DEPTH = 64,
   parameter int ADDR_WIDTH   = 6
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  clear,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [5:0]            op,
   input  logic [4:0]            rs,
   input  logic [4:0]            rt,
   input  logic [4:0]            rd,
   input  logic [4:0]            shamt,
   input  logic [5:0]            funct,
   input  logic [15:0]           imm,
   input  logic [25:0]           target,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [31:0]           mem_wdata,
   output logic [ADDR_WIDTH:0]   count,
   output logic                  full,
   output logic                  err
`ifdef INSTR_ENCODER_CHECKSUM_EN
   ,
   output logic [31:0]           checksum
`endif
);

   localparam logic [5:0] OP_R    = 6'h00;
   localparam logic [5:0] OP_J    = 6'h02;
   localparam logic [5:0] OP_JAL  = 6'h03;
   localparam logic [5:0] OP_BEQ  = 6'h04;
   localparam logic [5:0] OP_BNE  = 6'h05;
   localparam logic [5:0] OP_ADDI = 6'h08;
   localparam logic [5:0] OP_ORI  = 6'h0D;
   localparam logic [5:0] OP_LUI  = 6'h0F;
   localparam logic [ADDR_WIDTH:0] depthCount = (ADDR_WIDTH + 1)'(MEMORY_DEPTH);

   typedef enum logic [1:0] {IDLE, ENC, WR, FULL} state_t;

   state_t stateQ, stateD;

   logic [5:0]  opQ;
   logic [4:0]  rsQ, rtQ, rdQ, shamtQ;
   logic [5:0]  functQ;
   logic [15:0] immQ;
   logic [25:0] targetQ;

   logic        accept;
   logic        opOk;
   logic [31:0] encWord;
   logic [ADDR_WIDTH:0] countInc;

   assign countInc = count + 1'b1;
   assign in_ready = (stateQ == IDLE) && !reset;
   assign accept   = in_ready && in_valid && !clear;
   // A clear or reset in the write cycle drops the in-flight word.
   assign mem_we   = (stateQ == WR) && !clear && !reset;
   assign mem_addr = count[ADDR_WIDTH-1:0];
   assign full     = (count == depthCount);

   always_comb begin
      opOk    = 1'b1;
      encWord = 32'h0;
      case (opQ)
         OP_R:                             encWord = {OP_R, rsQ, rtQ, rdQ, shamtQ, functQ};
         OP_ADDI, OP_ORI, OP_BEQ, OP_BNE:  encWord = {opQ, rsQ, rtQ, immQ};
         OP_LUI:                           encWord = {opQ, 5'd0, rtQ, immQ};
         OP_J, OP_JAL:                     encWord = {opQ, targetQ};
         default:                          opOk    = 1'b0;
      endcase
   end

   always_comb begin
      stateD = stateQ;
      case (stateQ)
         IDLE:    if (accept) stateD = ENC;
         ENC:     stateD = opOk ? WR : IDLE;
         WR:      stateD = (countInc == depthCount) ? FULL : IDLE;
         FULL:    stateD = FULL;
         default: stateD = IDLE;
      endcase
      if (clear) stateD = IDLE;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         stateQ    <= IDLE;
         opQ       <= '0;
         rsQ       <= '0;
         rtQ       <= '0;
         rdQ       <= '0;
         shamtQ    <= '0;
         functQ    <= '0;
         immQ      <= '0;
         targetQ   <= '0;
         mem_wdata <= '0;
         count     <= '0;
         err       <= 1'b0;
      end else begin
         stateQ <= stateD;
         if (accept) begin
            opQ     <= op;
            rsQ     <= rs;
            rtQ     <= rt;
            rdQ     <= rd;
            shamtQ  <= shamt;
            functQ  <= funct;
            immQ    <= imm;
            targetQ <= target;
         end
         if (stateQ == ENC && opOk) mem_wdata <= encWord;
         if (clear) begin
            count <= '0;
            err   <= 1'b0;
         end else begin
            if (stateQ == ENC && !opOk) err <= 1'b1;
            if (mem_we) count <= countInc;
         end
      end
   end

`ifdef INSTR_ENCODER_CHECKSUM_EN
   always_ff @(posedge clk) begin
      if (reset || clear) checksum <= '0;
      else if (mem_we)    checksum <= checksum ^ mem_wdata;
   end
`endif

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: vector table, corner sequences and randomized bundles
// against a field-arithmetic reference model (small MEMORY_DEPTH so the full path is exercised).
module tb_instr_encoder;
   localparam int DEPTH = 4;
   localparam int AW    = 2;

   logic          clk = 1'b0;
   logic          reset, clear, in_valid, in_ready;
   logic [5:0]    op, funct;
   logic [4:0]    rs, rt, rd, shamt;
   logic [15:0]   imm;
   logic [25:0]   target;
   logic          mem_we, full, err;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_wdata;
   logic [AW:0]   count;
`ifdef INSTR_ENCODER_CHECKSUM_EN
   logic [31:0]   checksum;
`endif

   instr_encoder #(.MEMORY_DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
      .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
      .op(op), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct), .imm(imm),
      .target(target), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .count(count), .full(full), .err(err)
`ifdef INSTR_ENCODER_CHECKSUM_EN
      , .checksum(checksum)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int mCount = 0;
   logic [31:0] mSum = 32'h0;

   typedef struct {
      logic [5:0]  op;
      logic [4:0]  rs, rt, rd, shamt;
      logic [5:0]  funct;
      logic [15:0] imm;
      logic [25:0] target;
      bit          ok;
      logic [31:0] word;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference encoding built from field positions with plain arithmetic.
   function automatic bit refEnc(input int o, input int s, input int t, input int d, input int sh,
                                 input int f, input int im, input int tg, output logic [31:0] w);
      longint v;
      bit ok = 1;
      case (o)
         0:              v = s * 2**21 + t * 2**16 + d * 2**11 + sh * 64 + f;
         4, 5, 8, 13:    v = o * 2**26 + s * 2**21 + t * 2**16 + im;
         15:             v = o * 2**26 + t * 2**16 + im;
         2, 3:           v = o * 2**26 + tg;
         default: begin  v = 0; ok = 0; end
      endcase
      w = v[31:0];
      return ok;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic scramble();
      op = 6'($urandom); rs = 5'($urandom); rt = 5'($urandom); rd = 5'($urandom);
      shamt = 5'($urandom); funct = 6'($urandom); imm = 16'($urandom); target = 26'($urandom);
   endtask

   task automatic doClear();
      clear = 1'b1;
      tick();
      clear = 1'b0;
      mCount = 0;
      mSum = 32'h0;
      chk("clear_count", 32'(count), 0);
      chk("clear_err", 32'(err), 0);
      chk("clear_ready", 32'(in_ready), 1);
   endtask

   task automatic checkSum(input string name);
`ifdef INSTR_ENCODER_CHECKSUM_EN
      chk(name, checksum, mSum);
`else
      chk(name, 32'(count), 32'(mCount));
`endif
   endtask

   task automatic send(input vec_t v);
      if (mCount == DEPTH) begin
         chk("full_flag", 32'(full), 1);
         chk("full_ready", 32'(in_ready), 0);
         doClear();
      end
      op = v.op; rs = v.rs; rt = v.rt; rd = v.rd; shamt = v.shamt;
      funct = v.funct; imm = v.imm; target = v.target;
      in_valid = 1'b1;
      chk("accept_ready", 32'(in_ready), 1);
      tick();
      in_valid = 1'b0;
      scramble();
      chk("enc_we", 32'(mem_we), 0);
      chk("enc_ready", 32'(in_ready), 0);
      tick();
      if (v.ok) begin
         chk("wr_we", 32'(mem_we), 1);
         chk("wr_addr", 32'(mem_addr), 32'(mCount % DEPTH));
         chk("wr_data", mem_wdata, v.word);
         chk("wr_ready", 32'(in_ready), 0);
         tick();
         mCount++;
         mSum ^= v.word;
         chk("post_count", 32'(count), 32'(mCount));
         chk("post_we", 32'(mem_we), 0);
         chk("post_full", 32'(full), 32'(mCount == DEPTH));
         chk("post_ready", 32'(in_ready), 32'(mCount != DEPTH));
         checkSum("post_sum");
      end else begin
         chk("bad_we", 32'(mem_we), 0);
         chk("bad_err", 32'(err), 1);
         chk("bad_count", 32'(count), 32'(mCount));
         chk("bad_ready", 32'(in_ready), 1);
      end
   endtask

   function automatic vec_t mk(input int o, input int s, input int t, input int d, input int sh,
                               input int f, input int im, input int tg, input bit ok,
                               input logic [31:0] w);
      vec_t v;
      v.op = 6'(o); v.rs = 5'(s); v.rt = 5'(t); v.rd = 5'(d); v.shamt = 5'(sh);
      v.funct = 6'(f); v.imm = 16'(im); v.target = 26'(tg); v.ok = ok; v.word = w;
      return v;
   endfunction

   initial begin
      vec_t v;
      int   o;
      int   supOps[8] = '{0, 2, 3, 4, 5, 8, 13, 15};
      reset = 1'b1; clear = 1'b0; in_valid = 1'b0;
      scramble();
      tick();
      tick();
      chk("rst_ready_in_reset", 32'(in_ready), 0);
      chk("rst_we", 32'(mem_we), 0);
      chk("rst_addr", 32'(mem_addr), 0);
      chk("rst_wdata", mem_wdata, 0);
      chk("rst_count", 32'(count), 0);
      chk("rst_full", 32'(full), 0);
      chk("rst_err", 32'(err), 0);
      reset = 1'b0;
      tick();
      chk("rst_ready_after", 32'(in_ready), 1);
      checkSum("rst_sum");

      // ADDI, R, ORI, J, LUI, bad op, ADDI at same addr, BEQ, BNE, JAL
      vecs.push_back(mk(8'h08, 0, 8, 0, 0, 0, 16'h0005, 0, 1, 32'h20080005));
      vecs.push_back(mk(8'h00, 8, 9, 10, 0, 8'h20, 0, 0, 1, 32'h01095020));
      vecs.push_back(mk(8'h0D, 8, 9, 0, 0, 0, 16'h00FF, 0, 1, 32'h350900FF));
      vecs.push_back(mk(8'h02, 0, 0, 0, 0, 0, 0, 26'h0100008, 1, 32'h08100008));
      vecs.push_back(mk(8'h0F, 5, 1, 0, 0, 0, 16'h1001, 0, 1, 32'h3C011001));
      vecs.push_back(mk(8'h23, 1, 2, 3, 4, 5, 16'h1234, 26'h1, 0, 32'h0));
      vecs.push_back(mk(8'h08, 0, 8, 0, 0, 0, 16'h0005, 0, 1, 32'h20080005));
      vecs.push_back(mk(8'h04, 1, 2, 0, 0, 0, 16'hFFFF, 0, 1, 32'h1022FFFF));
      vecs.push_back(mk(8'h05, 3, 4, 0, 0, 0, 16'h0010, 0, 1, 32'h14640010));
      vecs.push_back(mk(8'h03, 0, 0, 0, 0, 0, 0, 26'h3FFFFFF, 1, 32'h0FFFFFFF));
      for (int i = 0; i < vecs.size(); i++) send(vecs[i]);

      // checksum excludes rejected words
      doClear();
      send(vecs[0]);
      send(vecs[5]);
      send(vecs[1]);
`ifdef INSTR_ENCODER_CHECKSUM_EN
      chk("sum_const", checksum, 32'h21015025);
`endif

      // fill to full, then hold in_valid with no effect
      doClear();
      for (int i = 0; i < DEPTH; i++) send(vecs[i]);
      chk("full_set", 32'(full), 1);
      in_valid = 1'b1;
      op = 6'h08;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("full_hold_we", 32'(mem_we), 0);
         chk("full_hold_count", 32'(count), DEPTH);
      end
      in_valid = 1'b0;
      doClear();

      // clear with in_valid in IDLE: not accepted
      v = vecs[0];
      op = v.op; rt = v.rt; imm = v.imm; rs = v.rs;
      in_valid = 1'b1; clear = 1'b1;
      tick();
      in_valid = 1'b0; clear = 1'b0;
      chk("clr_vs_valid_ready", 32'(in_ready), 1);
      tick();
      chk("clr_vs_valid_we", 32'(mem_we), 0);
      tick();
      chk("clr_vs_valid_count", 32'(count), 0);

      // reset during ENC drops the word
      send(vecs[0]);
      op = 6'h00; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      reset = 1'b1;
      tick();
      chk("rst_enc_we", 32'(mem_we), 0);
      chk("rst_enc_ready", 32'(in_ready), 0);
      chk("rst_enc_count", 32'(count), 0);
      reset = 1'b0;
      mCount = 0; mSum = 32'h0;
      tick();
      chk("rst_enc_we2", 32'(mem_we), 0);
      chk("rst_enc_ready2", 32'(in_ready), 1);
      checkSum("rst_enc_sum");

      // clear during WR drops the word
      send(vecs[1]);
      op = 6'h08; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      clear = 1'b1;
      #1;
      chk("clr_wr_we", 32'(mem_we), 0);
      tick();
      clear = 1'b0;
      mCount = 0; mSum = 32'h0;
      chk("clr_wr_count", 32'(count), 0);
      chk("clr_wr_ready", 32'(in_ready), 1);
      checkSum("clr_wr_sum");

      // randomized bundles against the reference model
      for (int i = 0; i < 80; i++) begin
         o = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 63)) : supOps[$urandom_range(0, 7)];
         v = mk(o, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
                $urandom_range(0, 31), $urandom_range(0, 63), $urandom_range(0, 65535),
                int'($urandom_range(0, 32'h3FFFFFF)), 0, 32'h0);
         v.ok = refEnc(int'(v.op), int'(v.rs), int'(v.rt), int'(v.rd), int'(v.shamt),
                       int'(v.funct), int'(v.imm), int'(v.target), v.word);
         send(v);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
